pulse_stretcher: RTL and testbench

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

---
 rtl/pulse_stretcher.sv | 124 ++++++++++++
 tb/tb_pulse_stretcher.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: widens trigger pulses into levels of programmable length,
// with retrigger, a one-deep pending trigger, a forced gap and a toggle mode.
module pulse_stretcher #(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             retrig,
    input  logic [CNT_W-1:0] len,
    input  logic             pulse_in,
    output logic             level_out,
    output logic             done,
    output logic             drop,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        TOG_HI = 2'd3
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    gcnt;
    logic             pending;
    logic [CNT_W-1:0] len_m1;

    // A zero length is treated as a one-cycle stretch.
    assign len_m1    = (len == '0) ? '0 : len - CNT_W'(1);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            level_out <= 1'b0;
            done      <= 1'b0;
            drop      <= 1'b0;
            cnt       <= '0;
            gcnt      <= '0;
            pending   <= 1'b0;
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                level_out <= 1'b0;
                cnt       <= '0;
                gcnt      <= '0;
                pending   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pulse_in) begin
                            level_out <= 1'b1;
                            if (mode) begin
                                state <= TOG_HI;
                            end else begin
                                state <= ACTIVE;
                                cnt   <= len_m1;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (pulse_in && retrig) begin
                            cnt <= len_m1;
                        end else begin
                            if (pulse_in) begin
                                if (pending) drop <= 1'b1;
                                else         pending <= 1'b1;
                            end
                            if (cnt == '0) begin
                                state     <= GAP;
                                level_out <= 1'b0;
                                done      <= 1'b1;
                                gcnt      <= GAP_LOAD;
                            end else begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    GAP: begin
                        if (gcnt == '0) begin
                            // A trigger on the final gap cycle re-arms pending
                            // if one is consumed now, otherwise starts directly.
                            if (pending || pulse_in) begin
                                state     <= ACTIVE;
                                level_out <= 1'b1;
                                cnt       <= len_m1;
                                pending   <= pending && pulse_in;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            gcnt <= gcnt - GW'(1);
                            if (pulse_in) begin
                                if (pending) drop <= 1'b1;
                                else         pending <= 1'b1;
                            end
                        end
                    end
                    TOG_HI: begin
                        if (pulse_in) begin
                            state     <= IDLE;
                            level_out <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        level_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random traffic, checked
// cycle by cycle against a remaining-cycles model of the stretcher.
module tb_pulse_stretcher;

    localparam int CNT_W = 16;
    localparam int GAP   = 2;

    logic             clk;
    logic             reset;
    logic             en;
    logic             mode;
    logic             retrig;
    logic [CNT_W-1:0] len;
    logic             pulse_in;
    logic             level_out;
    logic             done;
    logic             drop;
    logic [1:0]       state_dbg;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [2:0] exp_q[$];

    // Model: high cycles still to come, gap cycles still to come, pending, toggle.
    int   m_hi;
    int   m_gap;
    logic m_pend;
    logic m_tog;

    pulse_stretcher #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .retrig    (retrig),
        .len       (len),
        .pulse_in  (pulse_in),
        .level_out (level_out),
        .done      (done),
        .drop      (drop),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_hi   = 0;
        m_gap  = 0;
        m_pend = 1'b0;
        m_tog  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        int   eff;
        logic e_done;
        logic e_drop;
        eff    = (len == 0) ? 1 : int'(len);
        e_done = 1'b0;
        e_drop = 1'b0;
        if (!en) begin
            m_hi = 0; m_gap = 0; m_pend = 1'b0; m_tog = 1'b0;
        end else if (m_tog) begin
            if (pulse_in) m_tog = 1'b0;
        end else if (m_hi > 0) begin
            if (pulse_in && retrig) begin
                m_hi = eff;
            end else begin
                if (pulse_in) begin
                    if (m_pend) e_drop = 1'b1;
                    else        m_pend = 1'b1;
                end
                m_hi = m_hi - 1;
                if (m_hi == 0) begin
                    e_done = 1'b1;
                    m_gap  = GAP;
                end
            end
        end else if (m_gap > 0) begin
            if (m_gap == 1) begin
                m_gap = 0;
                if (m_pend) begin
                    m_hi = eff; m_pend = pulse_in;
                end else if (pulse_in) begin
                    m_hi = eff;
                end
            end else begin
                m_gap = m_gap - 1;
                if (pulse_in) begin
                    if (m_pend) e_drop = 1'b1;
                    else        m_pend = 1'b1;
                end
            end
        end else if (pulse_in) begin
            if (mode) m_tog = 1'b1;
            else      m_hi  = eff;
        end
        exp_q.push_back({(m_tog || m_hi > 0), e_done, e_drop});
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_outputs();
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            check_cnt++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            check_bit("level_out", level_out, e[2]);
            check_bit("done", done, e[1]);
            check_bit("drop", drop, e[0]);
        end
    endtask

    task automatic step(input logic e, input logic m, input logic r,
                        input logic [CNT_W-1:0] l, input logic p);
        en = e; mode = m; retrig = r; len = l; pulse_in = p;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n, input logic [CNT_W-1:0] l);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, l, 1'b0);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 1'b0; retrig = 1'b0; len = '0; pulse_in = 1'b0;
        model_reset();
        #12;
        check_bit("reset_level", level_out, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_bit("reset_drop", drop, 1'b0);
        reset = 1'b1;
        #10;

        // len=3 single pulse, plus explicit edge-by-edge expectations.
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        check_bit("s1_level_e0", level_out, 1'b1);
        idle_steps(2, 16'd3);
        check_bit("s1_level_e2", level_out, 1'b1);
        idle_steps(1, 16'd3);
        check_bit("s1_level_e3", level_out, 1'b0);
        check_bit("s1_done_e3", done, 1'b1);
        idle_steps(3, 16'd3);

        // len=0 behaves as a one-cycle stretch.
        step(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
        idle_steps(4, 16'd0);

        // Retrigger extends the level; one done at the end.
        step(1'b1, 1'b0, 1'b1, 16'd4, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'd4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd4, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 16'd4, 1'b0);

        // Back-to-back triggers without retrigger: pending then drop.
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        check_bit("s4_drop_e2", drop, 1'b1);
        idle_steps(10, 16'd3);

        // Toggle mode; mode flips while high are ignored.
        step(1'b1, 1'b1, 1'b0, 16'd3, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
        check_bit("s5_toggle_off", level_out, 1'b0);
        idle_steps(2, 16'd3);

        // Asynchronous reset in ACTIVE.
        step(1'b1, 1'b0, 1'b0, 16'd5, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_bit("async_reset_level", level_out, 1'b0);
        check_bit("async_reset_done", done, 1'b0);
        model_reset();
        #3 reset = 1'b1;
        idle_steps(3, 16'd5);

        // en=0 in GAP with a pending trigger discards it.
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'd2, 1'b1);
        idle_steps(6, 16'd2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1), CNT_W'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 3));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
